// File: rtl/reg_file.sv
// 32 x 32-bit register file: two combinational read ports, one clocked write port,
// asynchronous active-low clear, and debug taps on registers 0..6.
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] WRITE_DATA,
    input  logic [ADDR_WIDTH-1:0] WRITE_ADDR,
    input  logic                  WRITE_EN,
    input  logic [ADDR_WIDTH-1:0] ADDR_1,
    input  logic [ADDR_WIDTH-1:0] ADDR_2,
    output logic [DATA_WIDTH-1:0] DATA_1,
    output logic [DATA_WIDTH-1:0] DATA_2,
    output logic [DATA_WIDTH-1:0] REG0,
    output logic [DATA_WIDTH-1:0] REG1,
    output logic [DATA_WIDTH-1:0] REG2,
    output logic [DATA_WIDTH-1:0] REG3,
    output logic [DATA_WIDTH-1:0] REG4,
    output logic [DATA_WIDTH-1:0] REG5,
    output logic [DATA_WIDTH-1:0] REG6
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    // NOTE: start from the current contents so every path assigns regs_d and no latch is inferred.
    always_comb begin
        regs_d = regs_q;
        if (WRITE_EN) begin
            regs_d[WRITE_ADDR] = WRITE_DATA;
        end
    end

    // NOTE: the whole array is reset because software expects every register to read 0 after reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // No write-through: a same-cycle write becomes visible only after the edge.
    assign DATA_1 = regs_q[ADDR_1];
    assign DATA_2 = regs_q[ADDR_2];

    assign REG0 = regs_q[0];
    assign REG1 = regs_q[1];
    assign REG2 = regs_q[2];
    assign REG3 = regs_q[3];
    assign REG4 = regs_q[4];
    assign REG5 = regs_q[5];
    assign REG6 = regs_q[6];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed reset/write corner cases, a vector table,
// and a randomized phase checked against a reference array through a result queue.
module tb_reg_file;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] WRITE_DATA;
    logic [4:0]  WRITE_ADDR;
    logic        WRITE_EN;
    logic [4:0]  ADDR_1;
    logic [4:0]  ADDR_2;
    logic [31:0] DATA_1, DATA_2;
    logic [31:0] REG0, REG1, REG2, REG3, REG4, REG5, REG6;
    logic [31:0] tap [7];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    typedef struct {
        logic [31:0] exp1;
        logic [31:0] exp2;
        int          tag;
    } exp_t;

    vec_t        vecs [8];
    exp_t        sb_q [$];
    logic [31:0] model [32];

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .CLK(CLK), .RESET(RESET),
        .WRITE_DATA(WRITE_DATA), .WRITE_ADDR(WRITE_ADDR), .WRITE_EN(WRITE_EN),
        .ADDR_1(ADDR_1), .ADDR_2(ADDR_2),
        .DATA_1(DATA_1), .DATA_2(DATA_2),
        .REG0(REG0), .REG1(REG1), .REG2(REG2), .REG3(REG3),
        .REG4(REG4), .REG5(REG5), .REG6(REG6)
    );

    assign tap[0] = REG0;
    assign tap[1] = REG1;
    assign tap[2] = REG2;
    assign tap[3] = REG3;
    assign tap[4] = REG4;
    assign tap[5] = REG5;
    assign tap[6] = REG6;

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2);
        @(negedge CLK);
        WRITE_EN   = we;
        WRITE_ADDR = wa;
        WRITE_DATA = wd;
        ADDR_1     = a1;
        ADDR_2     = a2;
    endtask

    task automatic pop_compare(input logic [31:0] d1, input logic [31:0] d2);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("seq%0d_data1", e.tag), d1, e.exp1);
            check($sformatf("seq%0d_data2", e.tag), d2, e.exp2);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd7,  32'h1111_1111, 5'd7,  5'd0,  32'h1111_1111, 32'h0000_0000};
        vecs[1] = '{1'b1, 5'd8,  32'h2222_2222, 5'd7,  5'd8,  32'h1111_1111, 32'h2222_2222};
        vecs[2] = '{1'b0, 5'd7,  32'hFFFF_FFFF, 5'd7,  5'd8,  32'h1111_1111, 32'h2222_2222};
        vecs[3] = '{1'b1, 5'd7,  32'h3333_3333, 5'd7,  5'd7,  32'h3333_3333, 32'h3333_3333};
        vecs[4] = '{1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd30, 32'hCAFE_F00D, 32'h0000_0000};
        vecs[5] = '{1'b1, 5'd0,  32'h0000_0001, 5'd0,  5'd31, 32'h0000_0001, 32'hCAFE_F00D};
        vecs[6] = '{1'b1, 5'd31, 32'h0000_0000, 5'd31, 5'd8,  32'h0000_0000, 32'h2222_2222};
        vecs[7] = '{1'b0, 5'd8,  32'h0000_0000, 5'd8,  5'd7,  32'h2222_2222, 32'h3333_3333};

        RESET = 1'b0; WRITE_EN = 1'b0; WRITE_ADDR = '0; WRITE_DATA = '0;
        ADDR_1 = 5'd1; ADDR_2 = 5'd6;
        tick();
        tick();
        check("por_data1", DATA_1, 32'h0);
        check("por_reg0", REG0, 32'h0);
        @(negedge CLK);
        RESET = 1'b1;

        // Reset clears without a clock edge.
        for (int r = 1; r <= 6; r++) begin
            drive(1'b1, 5'(r), 32'hFFFF_FFFF, 5'd3, 5'd6);
            tick();
        end
        for (int r = 1; r <= 6; r++) check($sformatf("fill_reg%0d", r), tap[r], 32'hFFFF_FFFF);
        @(negedge CLK);
        WRITE_EN = 1'b0;
        RESET    = 1'b0;
        #1;
        for (int r = 0; r <= 6; r++) check($sformatf("async_clr_reg%0d", r), tap[r], 32'h0);
        check("async_clr_data1", DATA_1, 32'h0);
        check("async_clr_data2", DATA_2, 32'h0);
        @(negedge CLK);
        RESET = 1'b1;

        // Register 0 is ordinary storage.
        drive(1'b1, 5'd0, 32'hA5A5_A5A5, 5'd0, 5'd2);
        tick();
        @(negedge CLK);
        WRITE_EN = 1'b0;
        #1;
        check("wr0_reg0", REG0, 32'hA5A5_A5A5);
        check("wr0_data1", DATA_1, 32'hA5A5_A5A5);
        check("wr0_data2", DATA_2, 32'h0);

        drive(1'b1, 5'd1, 32'h1234_5678, 5'd3, 5'd4);
        tick();
        check("wr1_reg1", REG1, 32'h1234_5678);
        check("wr1_iso_data1", DATA_1, 32'h0);
        check("wr1_iso_data2", DATA_2, 32'h0);

        drive(1'b0, 5'd2, 32'hDEAD_BEEF, 5'd2, 5'd2);
        tick();
        check("we_gate_reg2", REG2, 32'h0);
        check("we_gate_data1", DATA_1, 32'h0);

        // Same register on both read ports and the write port.
        drive(1'b1, 5'd5, 32'hAAAA_5555, 5'd5, 5'd5);
        #1;
        check("rdw_pre_data1", DATA_1, 32'h0);
        check("rdw_pre_data2", DATA_2, 32'h0);
        tick();
        check("rdw_post_reg5", REG5, 32'hAAAA_5555);
        check("rdw_post_data1", DATA_1, 32'hAAAA_5555);
        check("rdw_post_data2", DATA_2, 32'hAAAA_5555);

        // Reset dominates a write on the same edge.
        drive(1'b1, 5'd6, 32'h1234_5678, 5'd6, 5'd7);
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        #1;
        check("rst_wr_reg6", REG6, 32'h0);
        check("rst_wr_data1", DATA_1, 32'h0);
        check("rst_wr_data2", DATA_2, 32'h0);
        check("rst_wr_reg0", REG0, 32'h0);
        check("rst_wr_reg1", REG1, 32'h0);
        check("rst_wr_reg5", REG5, 32'h0);
        @(negedge CLK);
        WRITE_EN = 1'b0;

        // Vector table: expected read values after each edge.
        for (int v = 0; v < 8; v++) begin
            drive(vecs[v].we, vecs[v].waddr, vecs[v].wdata, vecs[v].a1, vecs[v].a2);
            sb_q.push_back('{vecs[v].exp1, vecs[v].exp2, v});
            tick();
            pop_compare(DATA_1, DATA_2);
        end

        // Randomized traffic against a reference array, starting from a clean reset.
        @(negedge CLK);
        WRITE_EN = 1'b0;
        RESET    = 1'b0;
        #1;
        RESET    = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        for (int n = 0; n < 60; n++) begin
            logic        we;
            logic [4:0]  wa, a1, a2;
            logic [31:0] wd;
            we = ($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            a1 = (n % 5 == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = (n % 7 == 0) ? a1 : 5'($urandom_range(0, 31));
            drive(we, wa, wd, a1, a2);
            if (we) model[wa] = wd;
            sb_q.push_back('{model[a1], model[a2], 100 + n});
            tick();
            pop_compare(DATA_1, DATA_2);
        end
        for (int r = 0; r <= 6; r++) check($sformatf("rand_tap%0d", r), tap[r], model[r]);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry x 32-bit general-purpose register file for the RV32IM pipelined processor; sits between decode (read ports) and writeback (write port).
- Two asynchronous read ports and one synchronous write port.
- Debug taps expose registers 0..6 directly for bench and waveform visibility.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, address width; depth is 2**ADDR_WIDTH = 32 entries.

Ports:
- CLK  input  1  system clock; writes occur on the rising edge.
- RESET  input  1  asynchronous, active-low reset; clears every register.
- WRITE_DATA  input  32  data to write.
- WRITE_ADDR  input  5  destination register index.
- WRITE_EN  input  1  write enable, active high.
- ADDR_1  input  5  read port 1 index.
- ADDR_2  input  5  read port 2 index.
- DATA_1  output  32  contents of register ADDR_1.
- DATA_2  output  32  contents of register ADDR_2.
- REG0..REG6  output  32 each  continuous copies of registers 0..6.

Behaviour:
- Storage: 32 registers of 32 bits.
- Register 0 is ordinary writable storage here; x0 zero semantics are enforced outside this block.
- Reset:
  - RESET low immediately, without waiting for a clock edge, sets all 32 registers to 0.
  - While RESET is low, DATA_1, DATA_2 and REG0..REG6 all read 0.
  - Reset dominates writes: no write occurs while RESET is low, even with WRITE_EN=1 and a rising CLK edge.
  - Reset deassertion is asynchronous to CLK. The first write can occur on the first rising edge after RESET goes high.
- Write:
  - On a rising CLK edge with RESET high and WRITE_EN=1, reg[WRITE_ADDR] <= WRITE_DATA.
  - With WRITE_EN=0, no register changes.
  - Only one register is written per cycle.
- Read:
  - DATA_1 = reg[ADDR_1] and DATA_2 = reg[ADDR_2], purely combinational with no clock latency.
  - A change of ADDR_x is reflected in the same delta cycle.
- Read-during-write to the same address:
  - The read port shows the old value until the write edge, then the new value immediately after the edge.
  - There is no write-through bypass before the edge; forwarding is handled by the pipeline.
  - Both ports may address the same register, including the one being written, and then return identical values.
- Debug taps: REG0..REG6 are combinational copies of registers 0..6 and update immediately after a write edge.
- Addresses: all 5-bit addresses are valid, so there is no out-of-range case.
- X/undriven address or enable inputs outside reset are a usage error; the block has no defined behaviour for them.

Test Plan:
- Reset clears: write 32'hFFFFFFFF to regs 1..6, drive RESET low, do not toggle CLK -> REG0..REG6, DATA_1 and DATA_2 read 0 before the next edge.
- Write/read reg 0: RESET high, WRITE_ADDR=0, WRITE_DATA=32'hA5A5A5A5, WRITE_EN=1, one rising edge; then WRITE_EN=0, ADDR_1=0, ADDR_2=2 -> REG0=DATA_1=32'hA5A5A5A5, DATA_2=0.
- Write reg 1 and check isolation: WRITE_ADDR=1, WRITE_DATA=32'h12345678, one edge; then ADDR_1=3, ADDR_2=4 -> REG1=32'h12345678, DATA_1=DATA_2=0.
- Write-enable gating: WRITE_EN=0, WRITE_ADDR=2, WRITE_DATA=32'hDEADBEEF, one edge -> REG2 stays 0.
- Same-register read/write: ADDR_1=ADDR_2=WRITE_ADDR=5, WRITE_DATA=32'hAAAA5555, WRITE_EN=1 -> before the edge DATA_1=DATA_2=0; after the edge REG5=DATA_1=DATA_2=32'hAAAA5555.
- Write during reset: RESET low, WRITE_ADDR=6, WRITE_DATA=32'h12345678, WRITE_EN=1, ADDR_1=6, ADDR_2=7, apply an edge, then release RESET with no further edge -> REG6=DATA_1=DATA_2=0, and REG0/REG1/REG5 also 0.
